// File: rtl/candy_ctrl.sv
// candy_ctrl: control FSM for the candy machine coin accumulator.
// Sequences add/check/subtract, dispense and change handshakes.
module candy_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic [7:0] total,
  input  logic       cmp_ge80,
  input  logic       dispense_ack,
  input  logic       change_ack,
  output logic       ld,
  output logic       op,
  output logic       clr,
  output logic [1:0] sel,
  output logic       dispense,
  output logic       change_valid,
  output logic [7:0] change_amount,
  output logic       busy,
  output logic       coin_reject,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_WAIT, S_ADD, S_CHECK, S_SUB,
    S_DISP, S_CHANGE, S_CLR, S_FAULT
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  coin_q, coin_nx;
  logic [15:0] cnt, cnt_nx;
  logic [7:0]  amt_q, amt_nx;
  logic        rej_q, rej_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_WAIT;
      coin_q <= 2'b00;
      cnt    <= 16'd0;
      amt_q  <= 8'd0;
      rej_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      coin_q <= coin_nx;
      cnt    <= cnt_nx;
      amt_q  <= amt_nx;
      rej_q  <= rej_nx;
    end
  end

  // change amount is captured on entry to CHANGE so outputs stay Moore
  always_comb begin
    state_nx = state;
    coin_nx  = coin_q;
    cnt_nx   = cnt;
    amt_nx   = amt_q;
    rej_nx   = coin_valid &&
               !(state == S_WAIT && coin_type != 2'b00);
    unique case (state)
      S_WAIT: begin
        if (coin_valid && coin_type != 2'b00) begin
          coin_nx  = coin_type;
          state_nx = S_ADD;
        end else if (!coin_valid && cancel &&
                     total != 8'd0) begin
          amt_nx   = total;
          state_nx = S_CHANGE;
        end
      end
      S_ADD:   state_nx = S_CHECK;
      S_CHECK: state_nx = cmp_ge80 ? S_SUB : S_WAIT;
      S_SUB: begin
        cnt_nx   = 16'd0;
        state_nx = S_DISP;
      end
      S_DISP: begin
        cnt_nx = cnt + 16'd1;
        if (dispense_ack) begin
          if (total != 8'd0) begin
            amt_nx   = total;
            state_nx = S_CHANGE;
          end else begin
            state_nx = S_WAIT;
          end
        end else if (cnt == TO_LAST) begin
          state_nx = S_FAULT;
        end
      end
      S_CHANGE: if (change_ack) state_nx = S_CLR;
      S_CLR:    state_nx = S_WAIT;
      S_FAULT:  state_nx = S_FAULT;
      default:  state_nx = S_WAIT;
    endcase
  end

  always_comb begin
    ld            = 1'b0;
    op            = 1'b0;
    clr           = 1'b0;
    sel           = 2'b00;
    dispense      = 1'b0;
    change_valid  = 1'b0;
    change_amount = 8'd0;
    busy          = (state != S_WAIT);
    fault         = 1'b0;
    coin_reject   = rej_q;
    unique case (state)
      S_ADD: begin
        ld  = 1'b1;
        op  = 1'b1;
        sel = coin_q;
      end
      S_SUB:  ld = 1'b1;
      S_DISP: dispense = 1'b1;
      S_CHANGE: begin
        change_valid  = 1'b1;
        change_amount = amt_q;
      end
      S_CLR:   clr = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_candy_ctrl.sv
// tb_candy_ctrl: scoreboard bench for candy_ctrl with a
// behavioural accumulator datapath and directed coin sequences.
module tb_candy_ctrl;

  localparam int E_ADD = 1, E_SUB = 2, E_DISP = 3, E_CHG = 4;
  localparam int E_CLR = 5, E_REJ = 6, E_FLT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       cancel = 1'b0;
  logic [7:0] total;
  logic       cmp_ge80;
  logic       dispense_ack = 1'b0;
  logic       change_ack = 1'b0;
  logic       ld, op, clr, dispense, change_valid;
  logic       busy, coin_reject, fault;
  logic [1:0] sel;
  logic [7:0] change_amount;

  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];

  candy_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .total(total), .cmp_ge80(cmp_ge80),
    .dispense_ack(dispense_ack), .change_ack(change_ack),
    .ld(ld), .op(op), .clr(clr), .sel(sel),
    .dispense(dispense), .change_valid(change_valid),
    .change_amount(change_amount), .busy(busy),
    .coin_reject(coin_reject), .fault(fault)
  );

  always #5 clk = ~clk;

  // accumulator datapath model
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total <= 8'd0;
    else if (clr) total <= 8'd0;
    else if (ld && op)
      total <= total + ((sel == 2'd1) ? 8'd5 :
                        (sel == 2'd2) ? 8'd10 :
                        (sel == 2'd3) ? 8'd25 : 8'd0);
    else if (ld) total <= total - 8'd80;
  end
  assign cmp_ge80 = (total >= 8'd80);

  task automatic check(input string nm, input int act,
                       input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int ev(input int k, input int v);
    return k * 1000 + v;
  endfunction

  task automatic got(input string nm, input int k, input int v);
    int e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: unexpected event %0d with none expected",
               nm, ev(k, v));
    end else begin
      e = exp_q.pop_front();
      check(nm, ev(k, v), e);
    end
  endtask

  // monitor: turns DUT output activity into events
  logic p_disp = 1'b0, p_chg = 1'b0, p_flt = 1'b0;
  always @(negedge clk) begin
    if (ld && op)      got("add", E_ADD, int'(sel));
    if (ld && !op)     got("sub", E_SUB, int'(total));
    if (dispense && !p_disp) got("disp", E_DISP, int'(total));
    if (change_valid && !p_chg)
      got("change", E_CHG, int'(change_amount));
    if (clr)           got("clr", E_CLR, int'(total));
    if (coin_reject)   got("reject", E_REJ, int'(total));
    if (fault && !p_flt) got("fault", E_FLT, 0);
    p_disp = dispense;
    p_chg  = change_valid;
    p_flt  = fault;
  end

  function automatic logic [17:0] outs();
    return {ld, op, clr, sel, dispense, change_valid,
            change_amount, busy, coin_reject, fault};
  endfunction

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (busy && !dispense && !change_valid && !fault &&
           n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_chk++;
      $display("FAIL settle: timeout got %0d expected <50", n);
    end
  endtask

  task automatic coin(input logic [1:0] t, input logic c = 1'b0);
    @(posedge clk); #1;
    coin_valid = 1'b1; coin_type = t; cancel = c;
    @(posedge clk); #1;
    coin_valid = 1'b0; coin_type = 2'b00; cancel = 1'b0;
  endtask

  task automatic pay(input logic [1:0] t);
    exp_q.push_back(ev(E_ADD, int'(t)));
    coin(t);
    settle();
  endtask

  task automatic do_cancel();
    @(posedge clk); #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    settle();
  endtask

  task automatic ack_disp();
    @(posedge clk); #1 dispense_ack = 1'b1;
    @(posedge clk); #1 dispense_ack = 1'b0;
    settle();
  endtask

  task automatic ack_chg();
    @(posedge clk); #1 change_ack = 1'b1;
    @(posedge clk); #1 change_ack = 1'b0;
    settle();
  endtask

  initial begin
    int n;
    #2;
    check("reset_outs", int'(outs()), 0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // 25,25,25,5: exact 80, no change
    pay(2'd3); pay(2'd3); pay(2'd3);
    check("total_75", int'(total), 75);
    exp_q.push_back(ev(E_ADD, 1));
    exp_q.push_back(ev(E_SUB, 80));
    exp_q.push_back(ev(E_DISP, 0));
    coin(2'd1);
    settle();
    check("disp_held", int'(dispense), 1);
    repeat (2) @(negedge clk);
    check("disp_still", int'(dispense), 1);
    ack_disp();
    check("t1_total", int'(total), 0);
    check("t1_idle", int'(busy), 0);

    // 25,25,25,10: 5c change
    pay(2'd3); pay(2'd3); pay(2'd3);
    exp_q.push_back(ev(E_ADD, 2));
    exp_q.push_back(ev(E_SUB, 85));
    exp_q.push_back(ev(E_DISP, 5));
    coin(2'd2);
    settle();
    exp_q.push_back(ev(E_CHG, 5));
    ack_disp();
    exp_q.push_back(ev(E_CLR, 5));
    ack_chg();
    check("t2_total", int'(total), 0);

    // 10,10 then cancel: refund 20
    pay(2'd2); pay(2'd2);
    check("total_20", int'(total), 20);
    exp_q.push_back(ev(E_CHG, 20));
    do_cancel();
    exp_q.push_back(ev(E_CLR, 20));
    ack_chg();
    check("t3_total", int'(total), 0);
    do_cancel();
    repeat (3) @(negedge clk);
    check("cancel_zero", int'(change_valid | busy), 0);

    // rejects: invalid code in WAIT, coin during DISP
    exp_q.push_back(ev(E_REJ, 0));
    coin(2'd0);
    @(negedge clk);
    check("rej_total", int'(total), 0);
    pay(2'd3); pay(2'd3); pay(2'd3);
    exp_q.push_back(ev(E_ADD, 1));
    exp_q.push_back(ev(E_SUB, 80));
    exp_q.push_back(ev(E_DISP, 0));
    coin(2'd1);
    settle();
    exp_q.push_back(ev(E_REJ, 0));
    coin(2'd2);
    @(negedge clk);
    check("rej_disp_total", int'(total), 0);
    ack_disp();
    // coin beats cancel in the same cycle
    pay(2'd1);
    exp_q.push_back(ev(E_ADD, 2));
    coin(2'd2, 1'b1);
    settle();
    check("coin_prio", int'(total), 15);
    exp_q.push_back(ev(E_CHG, 15));
    do_cancel();
    exp_q.push_back(ev(E_CLR, 15));
    ack_chg();

    // dispense timeout
    pay(2'd3); pay(2'd3); pay(2'd3);
    exp_q.push_back(ev(E_ADD, 1));
    exp_q.push_back(ev(E_SUB, 80));
    exp_q.push_back(ev(E_DISP, 0));
    exp_q.push_back(ev(E_FLT, 0));
    coin(2'd1);
    settle();
    n = 0;
    while (dispense && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("disp_cycles", n, 4);
    check("fault_set", int'(fault), 1);
    exp_q.push_back(ev(E_REJ, 0));
    coin(2'd3);
    repeat (5) @(negedge clk);
    check("fault_sticky", int'({fault, busy, ld}), 6);
    #2 rst_n = 1'b0;
    #1 check("fault_reset", int'(outs()), 0);
    @(negedge clk) rst_n = 1'b1;

    // reset during ADD
    coin(2'd2);
    check("in_add", int'(ld), 1);
    rst_n = 1'b0;
    #1 check("rst_add_outs", int'(outs()), 0);
    @(negedge clk);
    check("rst_add_total", int'(total), 0);
    rst_n = 1'b1;
    pay(2'd2);
    check("post_rst_total", int'(total), 10);
    // reset during CHANGE
    exp_q.push_back(ev(E_CHG, 10));
    do_cancel();
    #1 rst_n = 1'b0;
    #1 check("rst_chg_outs", int'(outs()), 0);
    @(negedge clk) rst_n = 1'b1;
    pay(2'd1);
    check("final_total", int'(total), 5);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
